// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit_pkg
// Brief  : Shared pipeline types and constants for the MEM stage.
// Rev    : 1.0 - initial release
// ============================================================================
package mem_access_unit_pkg;

  localparam logic [31:0] ZERO    = 32'h0000_0000;
  localparam logic        DISABLE = 1'b0;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_source_type;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_access_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit_if
// Brief  : Data-memory request/acknowledge bus between MEM stage and memory.
// Rev    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;

  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o,
    output dmem_we_o,
    output dmem_addr_o,
    output dmem_wdata_o,
    input  dmem_ack_i,
    input  dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o,
    input  dmem_we_o,
    input  dmem_addr_o,
    input  dmem_wdata_o,
    output dmem_ack_i,
    output dmem_rdata_i
  );

endinterface
`default_nettype wire

// File: rtl/mem_access_unit_access_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module : access_timeout_counter
// Brief  : Counts enabled cycles; expired flags the last permitted cycle.
// Rev    : 1.0 - initial release
// ============================================================================
module access_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic clk_i,
  input  wire logic n_rst,
  input  wire logic clear,
  input  wire logic enable,
  output logic      expired
);

  localparam int                  c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;

  // expired is raised during the TIMEOUT_CYCLES-th enabled cycle
  assign expired = enable && (r_count == c_LAST);

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : mem_access_unit
// Brief  : MEM-stage data-memory sequencer with timeout and branch redirect.
// Rev    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic          clk_i,
  input  wire logic          n_rst,
  input  wire logic          mem_memread_en_i,
  input  wire logic          mem_memwrite_en_i,
  input  wire logic [31:0]   mem_alu_result_i,
  input  wire logic [31:0]   mem_wdata_i,
  input  wire logic          mem_branch_i,
  input  wire logic          mem_jmp_i,
  input  wire logic          mem_alu_zero_i,
  input  wire logic [31:0]   mem_pc_imm_i,
  mem_access_unit_if.master  dmem,
  output logic               stall_o,
  output logic [31:0]        rdata_o,
  output logic               rdata_valid_o,
  output logic               bus_err_o,
  output logic               pc_redirect_o,
  output logic               flush_o,
  output logic [31:0]        pc_target_o
);

  mem_access_state_e r_state;
  mem_access_state_e w_state_next;

  logic        w_mem_op;
  logic        w_in_access;
  logic        w_expired;
  logic        w_latch;
  logic        w_finish;
  logic        w_timeout;
  logic        w_addr_unused;

  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_is_load;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  assign w_mem_op      = mem_memread_en_i | mem_memwrite_en_i;
  assign w_in_access   = (r_state == ST_ACCESS);
  assign w_addr_unused = ^mem_alu_result_i[1:0];

  access_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (clk_i),
    .n_rst   (n_rst),
    .clear   (!w_in_access),
    .enable  (w_in_access),
    .expired (w_expired)
  );

  always_comb begin
    w_state_next = r_state;
    w_latch      = DISABLE;
    w_finish     = DISABLE;
    w_timeout    = DISABLE;
    unique case (r_state)
      ST_IDLE: begin
        if (w_mem_op) begin
          w_state_next = ST_ACCESS;
          w_latch      = 1'b1;
        end
      end
      ST_ACCESS: begin
        // an ack arriving on the expiry cycle completes normally
        if (dmem.dmem_ack_i || w_expired) begin
          w_state_next = ST_DONE;
          w_finish     = 1'b1;
          w_timeout    = !dmem.dmem_ack_i;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_addr    <= ZERO;
      r_wdata   <= ZERO;
      r_we      <= DISABLE;
      r_is_load <= DISABLE;
      r_rdata   <= ZERO;
      r_bus_err <= DISABLE;
    end else begin
      r_state   <= w_state_next;
      r_bus_err <= w_timeout;
      if (w_latch) begin
        r_addr    <= {mem_alu_result_i[31:2], 2'b00};
        r_wdata   <= mem_wdata_i;
        r_we      <= mem_memwrite_en_i;
        r_is_load <= mem_memread_en_i & ~mem_memwrite_en_i;
      end
      if (w_finish) begin
        r_rdata <= (dmem.dmem_ack_i && r_is_load) ? dmem.dmem_rdata_i : ZERO;
      end
    end
  end

  assign dmem.dmem_req_o   = w_in_access;
  assign dmem.dmem_we_o    = r_we;
  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_wdata_o = r_wdata;

  assign stall_o       = w_mem_op && (r_state != ST_DONE);
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = (r_state == ST_DONE) && r_is_load;
  assign bus_err_o     = r_bus_err;

  // a stalled MEM stage must not redirect until its access completes
  assign pc_redirect_o = ((mem_branch_i & mem_alu_zero_i) | mem_jmp_i) & ~stall_o;
  assign flush_o       = pc_redirect_o;
  assign pc_target_o   = mem_pc_imm_i;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_access_unit
// Brief  : Directed self-checking bench with a transaction-level output model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        n_rst;
  logic        sel;
  logic        rd, wr, ack, br, jmp, zero;
  logic [31:0] addr, wdata, pc_imm, rdv;
  int          tmo;

  logic        stall_a, valid_a, err_a, redir_a, flush_a;
  logic        stall_b, valid_b, err_b, redir_b, flush_b;
  logic [31:0] rdata_a, target_a, rdata_b, target_b;

  mem_access_unit_if if_a ();
  mem_access_unit_if if_b ();

  assign if_a.dmem_ack_i   = ack & ~sel;
  assign if_a.dmem_rdata_i = rdv;
  assign if_b.dmem_ack_i   = ack & sel;
  assign if_b.dmem_rdata_i = rdv;

  mem_access_unit dut_a (
    .clk_i (clk_i), .n_rst (n_rst),
    .mem_memread_en_i (rd & ~sel), .mem_memwrite_en_i (wr & ~sel),
    .mem_alu_result_i (addr), .mem_wdata_i (wdata),
    .mem_branch_i (br), .mem_jmp_i (jmp), .mem_alu_zero_i (zero),
    .mem_pc_imm_i (pc_imm), .dmem (if_a.master),
    .stall_o (stall_a), .rdata_o (rdata_a), .rdata_valid_o (valid_a),
    .bus_err_o (err_a), .pc_redirect_o (redir_a), .flush_o (flush_a),
    .pc_target_o (target_a)
  );

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_b (
    .clk_i (clk_i), .n_rst (n_rst),
    .mem_memread_en_i (rd & sel), .mem_memwrite_en_i (wr & sel),
    .mem_alu_result_i (addr), .mem_wdata_i (wdata),
    .mem_branch_i (br), .mem_jmp_i (jmp), .mem_alu_zero_i (zero),
    .mem_pc_imm_i (pc_imm), .dmem (if_b.master),
    .stall_o (stall_b), .rdata_o (rdata_b), .rdata_valid_o (valid_b),
    .bus_err_o (err_b), .pc_redirect_o (redir_b), .flush_o (flush_b),
    .pc_target_o (target_b)
  );

  logic        m_stall, m_valid, m_err, m_redir, m_flush, m_req, m_we;
  logic [31:0] m_rdata, m_target, m_addr, m_wdata;
  assign m_stall  = sel ? stall_b  : stall_a;
  assign m_valid  = sel ? valid_b  : valid_a;
  assign m_err    = sel ? err_b    : err_a;
  assign m_redir  = sel ? redir_b  : redir_a;
  assign m_flush  = sel ? flush_b  : flush_a;
  assign m_rdata  = sel ? rdata_b  : rdata_a;
  assign m_target = sel ? target_b : target_a;
  assign m_req    = sel ? if_b.dmem_req_o   : if_a.dmem_req_o;
  assign m_we     = sel ? if_b.dmem_we_o    : if_a.dmem_we_o;
  assign m_addr   = sel ? if_b.dmem_addr_o  : if_a.dmem_addr_o;
  assign m_wdata  = sel ? if_b.dmem_wdata_o : if_a.dmem_wdata_o;

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        stall, req, valid, err, redir, chk_bus, we, chk_rd;
    logic [31:0] addr, wdata, rdata, target;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model's expected outputs
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      chk("stall", m_stall, cur.stall);
      chk("req", m_req, cur.req);
      chk("valid", m_valid, cur.valid);
      chk("bus_err", m_err, cur.err);
      chk("redirect", m_redir, cur.redir);
      chk("flush", m_flush, cur.redir);
      chk("target", m_target, cur.target);
      if (cur.chk_bus) begin
        chk("we", m_we, cur.we);
        chk("addr", m_addr, cur.addr);
        chk("wdata", m_wdata, cur.wdata);
      end
      if (cur.chk_rd) chk("rdata", m_rdata, cur.rdata);
    end
  end

  int          stall_cnt = 0, acc_cnt = 0, err_cnt = 0, valid_cnt = 0;
  logic [31:0] last_addr = 32'h0;
  logic        last_we = 1'b0;
  always @(negedge clk_i) begin
    if (m_stall) stall_cnt++;
    if (m_err)   err_cnt++;
    if (m_valid) valid_cnt++;
    if (m_req) begin
      acc_cnt++;
      last_addr = m_addr;
      last_we   = m_we;
    end
  end

  task automatic drive_cycle(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic k,
                             input logic [31:0] rv, input exp_t e);
    exp_t x;
    @(posedge clk_i); #1;
    rd = r; wr = w; addr = a; wdata = d; ack = k; rdv = rv;
    x        = e;
    x.redir  = ((br & zero) | jmp) & ~e.stall;
    x.target = pc_imm;
    exp_q.push_back(x);
    @(negedge clk_i); #1;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = '{default: '0};
      drive_cycle(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, e);
    end
  endtask

  // ack_at: ACCESS cycle (1-based) carrying the ack; 0 means no ack at all
  task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input int ack_at, input logic [31:0] rv);
    exp_t e;
    logic ld, acked, hit;
    int   n;
    ld    = r & ~w;
    acked = (ack_at >= 1) && (ack_at <= tmo);
    n     = acked ? ack_at : tmo;
    e = '{default: '0};
    e.stall = 1'b1;
    drive_cycle(r, w, a, d, 1'b1, 32'hBAD0_0001, e);
    for (int i = 1; i <= n; i++) begin
      e = '{default: '0};
      e.stall = 1'b1; e.req = 1'b1; e.chk_bus = 1'b1;
      e.we = w; e.addr = a & 32'hFFFF_FFFC; e.wdata = d;
      hit = acked && (i == n);
      drive_cycle(r, w, a, d, hit, hit ? rv : 32'($urandom), e);
    end
    e = '{default: '0};
    e.valid  = ld;
    e.err    = ~acked;
    e.chk_rd = 1'b1;
    e.rdata  = (acked && ld) ? rv : 32'h0;
    drive_cycle(r, w, a, d, 1'b1, 32'hBAD0_0002, e);
  endtask

  int   base_s, base_a, base_e, base_v;
  exp_t e0;

  initial begin
    n_rst = 1'b0; sel = 1'b0; tmo = 16;
    rd = 1'b0; wr = 1'b0; ack = 1'b0; br = 1'b0; jmp = 1'b0; zero = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc_imm = 32'h0; rdv = 32'h0;
    repeat (2) @(negedge clk_i);
    chk("rst_req", if_a.dmem_req_o, 32'h0);
    chk("rst_we", if_a.dmem_we_o, 32'h0);
    chk("rst_addr", if_a.dmem_addr_o, 32'h0);
    chk("rst_wdata", if_a.dmem_wdata_o, 32'h0);
    chk("rst_rdata", rdata_a, 32'h0);
    chk("rst_valid", valid_a, 32'h0);
    chk("rst_err", err_a, 32'h0);
    n_rst = 1'b1;
    idle(2);

    br = 1'b1; zero = 1'b1; pc_imm = 32'h80;
    idle(1);
    chk("lit_redirect", m_redir, 32'h1);
    chk("lit_flush", m_flush, 32'h1);
    chk("lit_target", m_target, 32'h80);
    zero = 1'b0;
    idle(1);
    chk("lit_no_redirect", m_redir, 32'h0);
    br = 1'b0;

    base_s = stall_cnt;
    run_txn(1'b1, 1'b0, 32'h0000_1006, 32'h0, 1, 32'hDEAD_BEEF);
    chk("lit_ld_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("lit_ld_valid", m_valid, 32'h1);
    chk("lit_ld_addr", last_addr, 32'h0000_1004);
    chk("lit_ld_stall", 32'(stall_cnt - base_s), 32'd2);
    idle(1);

    base_a = acc_cnt; base_v = valid_cnt;
    run_txn(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5, 32'hFFFF_0000);
    chk("lit_st_we", last_we, 32'h1);
    chk("lit_st_cycles", 32'(acc_cnt - base_a), 32'd5);
    chk("lit_st_novalid", 32'(valid_cnt - base_v), 32'd0);

    jmp = 1'b1; pc_imm = 32'h0000_0400;
    run_txn(1'b1, 1'b0, 32'h0000_3003, 32'h0, 3, 32'h0BAD_F00D);
    jmp = 1'b0;
    run_txn(1'b1, 1'b1, 32'h0000_0044, 32'hCAFE_0001, 2, 32'h5555_AAAA);
    run_txn(1'b1, 1'b0, 32'h0000_0048, 32'h0, 16, 32'h1357_9BDF);
    idle(1);

    sel = 1'b1; tmo = 4;
    idle(1);
    base_a = acc_cnt; base_e = err_cnt;
    run_txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'h0);
    chk("lit_to_rdata", m_rdata, 32'h0);
    chk("lit_to_cycles", 32'(acc_cnt - base_a), 32'd4);
    idle(2);
    chk("lit_to_pulses", 32'(err_cnt - base_e), 32'd1);
    base_e = err_cnt;
    run_txn(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4, 32'hA5A5_5A5A);
    chk("lit_edge_rdata", m_rdata, 32'hA5A5_5A5A);
    idle(1);
    chk("lit_edge_noerr", 32'(err_cnt - base_e), 32'd0);
    run_txn(1'b0, 1'b1, 32'h0000_0108, 32'h7777_8888, 0, 32'h0);
    idle(1);

    sel = 1'b0; tmo = 16;
    idle(1);
    e0 = '{default: '0};
    e0.stall = 1'b1;
    drive_cycle(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'h0, e0);
    e0.req = 1'b1; e0.chk_bus = 1'b1; e0.addr = 32'h0000_0200;
    drive_cycle(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'h0, e0);
    drive_cycle(1'b1, 1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'h0, e0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_req", if_a.dmem_req_o, 32'h0);
    chk("arst_addr", if_a.dmem_addr_o, 32'h0);
    chk("arst_we", if_a.dmem_we_o, 32'h0);
    chk("arst_rdata", rdata_a, 32'h0);
    chk("arst_valid", valid_a, 32'h0);
    chk("arst_err", err_a, 32'h0);
    rd = 1'b0;
    @(negedge clk_i);
    n_rst = 1'b1;
    idle(2);
    run_txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 2, 32'h2468_ACE0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
